// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller:
// scoreboard slot layout, memory-wait states, register index width.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W = 4;

  typedef struct packed {
    logic             valid;
    logic             wb;
    logic             mem_r;
    logic             mem_w;
    logic [REG_W-1:0] dest;
  } slot_t;

  typedef enum logic {
    IDLE,
    WAIT
  } wait_st_t;

endpackage

// File: rtl/pipe_mem_wait_fsm.sv
// Tracks multi-cycle SRAM waits for the instruction in MEM,
// with a bounded wait that forces release and latches an error.
module pipe_mem_wait_fsm
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_busy,
  input  logic mem_ready,
  output logic mem_stall,
  output logic mem_err
);

  localparam logic [7:0] TO = 8'(MEM_TIMEOUT);

  wait_st_t   st;
  logic [7:0] wait_cnt;
  logic       release_to;

  assign release_to = (st == WAIT) & (wait_cnt == TO);
  assign mem_stall  = mem_busy & ~release_to;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (mem_busy) begin
            st       <= WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          if (mem_ready) begin
            st <= IDLE;
          end else if (wait_cnt == TO) begin
            st      <= IDLE;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline enable/clear generator: shadow EXE/MEM scoreboard,
// RAW hazard detection, branch flush and memory-wait freeze.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter bit FWD_EN      = 1'b0,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_use_src1,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             id_mem_w_en,
  input  logic [REG_W-1:0] id_dest,
  input  logic             exe_branch_taken,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_clr,
  output logic             id_ex_en,
  output logic             id_ex_clr,
  output logic             exe_mem_en,
  output logic             mem_wb_en,
  output logic             mem_err,
  output logic [31:0]      stall_cnt
);

  slot_t      exe_s, mem_s, id_s;
  logic       rd1, rd2;
  logic       hz_exe, hz_mem, hz;
  logic       mem_busy, mem_stall;
  logic       sel_br, sel_hz;
  logic [6:0] ctl;

  function automatic logic hit(
    input slot_t            s,
    input logic [REG_W-1:0] src
  );
    return s.valid & s.wb & (s.dest == src);
  endfunction

  assign rd1 = id_valid & id_use_src1;
  assign rd2 = id_valid & id_two_src;

  assign hz_exe = (rd1 & hit(exe_s, id_src1))
                | (rd2 & hit(exe_s, id_src2));
  assign hz_mem = (rd1 & hit(mem_s, id_src1))
                | (rd2 & hit(mem_s, id_src2));

  // With forwarding only a load still in EXE cannot be bypassed
  assign hz = FWD_EN ? (hz_exe & exe_s.mem_r)
                     : (hz_exe | hz_mem);

  assign mem_busy = mem_s.valid
                  & (mem_s.mem_r | mem_s.mem_w)
                  & ~mem_ready;

  pipe_mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait (
    .clk      (clk),
    .rst      (rst),
    .mem_busy (mem_busy),
    .mem_ready(mem_ready),
    .mem_stall(mem_stall),
    .mem_err  (mem_err)
  );

  assign sel_br = ~mem_stall & exe_branch_taken;
  assign sel_hz = ~mem_stall & ~exe_branch_taken & hz;

  assign id_s = '{
    valid: 1'b1,
    wb:    id_wb_en,
    mem_r: id_mem_r_en,
    mem_w: id_mem_w_en,
    dest:  id_dest
  };

  always_comb begin
    ctl = 7'b1101011;
    unique case (1'b1)
      mem_stall: ctl = 7'b0000000;
      sel_br:    ctl = 7'b1111111;
      sel_hz:    ctl = 7'b0001111;
      default:   ctl = 7'b1101011;
    endcase
  end

  assign {pc_en, if_id_en, if_id_clr, id_ex_en,
          id_ex_clr, exe_mem_en, mem_wb_en} = ctl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_s <= '0;
      mem_s <= '0;
    end else if (!mem_stall) begin
      mem_s <= exe_s;
      exe_s <= (id_valid & ~hz & ~exe_branch_taken)
             ? id_s : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (!pc_en) stall_cnt <= stall_cnt + 32'd1;
  end

endmodule
